id_ex_hazard_stage: RTL
=======================

Name: id_ex_hazard_stage

Overview:
- Parametrised ID/EX pipeline stage that replaces the combinational control-bubble mux and the fixed-width operand muxes.
- Registers the decoded control word and two forwarded operands, each selected from NUM_SRC sources.
- Detects load-use hazards internally and inserts BUBBLE_CYCLES zero-control bubbles while asserting stall upstream.
- Handles external hold and flush.

Parameters:
- DATA_W, 32, operand width.
- CTRL_W, 27, packed control-word width (load, RF enable, RAM enable/RW/SE/size, JAL/JALR/AUIPC, ALU op, shift imm, opfunct).
- NUM_SRC, 4, forwarding sources per operand (2..8).
- SEL_W, $clog2(NUM_SRC), selector width.
- BUBBLE_CYCLES, 1, bubbles inserted per load-use hazard (1..4).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- hold_in  in  1  external stall; freeze stage and FSM.
- flush_in  in  1  squash stage contents (branch or jump taken).
- id_valid_in  in  1  ID holds a real instruction.
- id_ctrl_in  in  CTRL_W  control word from the control unit.
- id_load_in  in  1  ID instruction is a load.
- id_rd_in, id_rs1_in, id_rs2_in  in  5  register indices.
- fwd_src_in  in  NUM_SRC*DATA_W  flattened sources; source k occupies bits [k*DATA_W +: DATA_W].
- fwd_sel1_in, fwd_sel2_in  in  SEL_W  operand source selects.
- ex_valid_out  out  1  EX holds a real instruction.
- ex_ctrl_out  out  CTRL_W  registered control word.
- ex_load_out  out  1  registered load flag.
- ex_rd_out  out  5  registered destination register.
- ex_op1_out, ex_op2_out  out  DATA_W  registered operands.
- stall_out  out  1  combinational; freeze PC and IF/ID.
- bubble_out  out  1  registered; high for each cycle EX holds an inserted bubble.

Behaviour:
- Reset (async): all outputs 0; FSM to IDLE; bubble counter 0.
- hazard = ex_valid_out & ex_load_out & (ex_rd_out != 0) & id_valid_in & ((ex_rd_out == id_rs1_in) | (ex_rd_out == id_rs2_in)).
- FSM states: IDLE, BUBBLE; 2-bit down-counter cnt.
- IDLE, hazard, no flush/hold: load a bubble. If BUBBLE_CYCLES > 1, go to BUBBLE with cnt = BUBBLE_CYCLES-2; otherwise stay in IDLE.
- BUBBLE, no flush/hold: load a bubble. If cnt == 0, go to IDLE; else decrement cnt.
- stall_out = ~flush_in & ((state == IDLE & hazard) | state == BUBBLE).
- Bubble load: ex_valid_out = 0, ex_ctrl_out = 0, ex_load_out = 0, ex_rd_out = 0, operands = 0, bubble_out = 1.
- Normal load: ex_valid_out = id_valid_in, ex_ctrl_out = id_ctrl_in, ex_load_out = id_load_in, ex_rd_out = id_rd_in, op1 = src[fwd_sel1_in], op2 = src[fwd_sel2_in], bubble_out = 0.
- Per-edge priority: flush_in > hold_in > bubble > normal.
  - flush_in: stage zeroed, bubble_out = 0, FSM to IDLE, cnt = 0.
  - hold_in: all registers, FSM and cnt unchanged; stall_out is still evaluated.
- Selector >= NUM_SRC (non-power-of-2 NUM_SRC): select source 0.
- Latency: exactly 1 cycle from ID inputs to EX outputs. No combinational path from fwd_src_in to any output.
- A hazard with ex_rd_out == 0 never stalls.
- Flush during BUBBLE aborts the remaining bubbles.
- Hold during BUBBLE extends the stall without consuming cnt.

Optional Feature:
- Macro: ID_EX_BUBBLE_COUNT_EN.
- Defined:
  - Adds output bubble_count_out [31:0].
  - Increments once per clock edge where a bubble is loaded; saturates at 32'hFFFF_FFFF.
  - Cleared only by reset; unaffected by flush and hold.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: assert reset mid-cycle with EX valid -> all outputs 0 immediately, without waiting for a clock edge; release; next edge with id_valid_in = 1, id_ctrl_in = 27'h1234 -> ex_ctrl_out = 27'h1234, ex_valid_out = 1.
- Forwarding, NUM_SRC = 4, sources {4'hA, 4'hB, 4'hC, 4'hD} extended to 32 bits, sel1 = 2, sel2 = 3 -> ex_op1_out = 32'hC, ex_op2_out = 32'hD one cycle later.
- Load-use, BUBBLE_CYCLES = 1: EX holds a valid load with rd = 5; ID has rs2 = 5 -> stall_out = 1 that cycle; next cycle ex_valid_out = 0, ex_ctrl_out = 0, bubble_out = 1, stall_out = 0; following cycle ID instruction enters EX.
- BUBBLE_CYCLES = 3 with hold_in = 1 for 1 cycle during BUBBLE -> stall_out high 4 cycles; exactly 3 bubble_out pulses.
- No-stall cases: load with rd = 0 matching rs1 = 0 -> stall_out = 0. Hazard plus flush_in in the same cycle -> stall_out = 0, stage zeroed, bubble_out = 0.
- ID_EX_BUBBLE_COUNT_EN defined: three separate hazards with BUBBLE_CYCLES = 2 -> bubble_count_out = 6.

Source files
------------

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline stage: registers control and forwarded operands, inserts load-use bubbles.
// Optional macro ID_EX_BUBBLE_COUNT_EN adds a saturating bubble counter output.
module id_ex_hazard_stage #(
  parameter int DATA_W        = 32,
  parameter int CTRL_W        = 27,
  parameter int NUM_SRC       = 4,
  parameter int SEL_W         = $clog2(NUM_SRC),
  parameter int BUBBLE_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold_in,
  input  logic                      flush_in,
  input  logic                      id_valid_in,
  input  logic [CTRL_W-1:0]         id_ctrl_in,
  input  logic                      id_load_in,
  input  logic [4:0]                id_rd_in,
  input  logic [4:0]                id_rs1_in,
  input  logic [4:0]                id_rs2_in,
  input  logic [NUM_SRC*DATA_W-1:0] fwd_src_in,
  input  logic [SEL_W-1:0]          fwd_sel1_in,
  input  logic [SEL_W-1:0]          fwd_sel2_in,
  output logic                      ex_valid_out,
  output logic [CTRL_W-1:0]         ex_ctrl_out,
  output logic                      ex_load_out,
  output logic [4:0]                ex_rd_out,
  output logic [DATA_W-1:0]         ex_op1_out,
  output logic [DATA_W-1:0]         ex_op2_out,
  output logic                      stall_out,
  output logic                      bubble_out
`ifdef ID_EX_BUBBLE_COUNT_EN
  ,
  output logic [31:0]               bubble_count_out
`endif
);

  typedef enum logic {S_IDLE, S_BUBBLE} state_t;

  // Counter value on entering BUBBLE: the first bubble is loaded from IDLE.
  localparam logic [1:0] CNT_INIT = (BUBBLE_CYCLES > 1) ? 2'(BUBBLE_CYCLES - 2) : 2'd0;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic                load_q, load_d;
  logic [4:0]          rd_q, rd_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic                bubble_q, bubble_d;

  logic                hazard;
  logic                in_bubble;
  logic                bubble_load;
  logic [DATA_W-1:0]   op1_sel, op2_sel;

  // Out-of-range selects (non-power-of-2 NUM_SRC) fall back to source 0.
  function automatic logic [DATA_W-1:0] sel_src(input logic [NUM_SRC*DATA_W-1:0] src,
                                                input logic [SEL_W-1:0]          sel);
    logic [DATA_W-1:0] r;
    r = src[DATA_W-1:0];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) r = src[k*DATA_W +: DATA_W];
    end
    return r;
  endfunction

`ifdef ID_EX_BUBBLE_COUNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  always_comb begin
    hazard = valid_q & load_q & (rd_q != 5'd0) & id_valid_in &
             ((rd_q == id_rs1_in) | (rd_q == id_rs2_in));
    in_bubble   = ((state_q == S_IDLE) & hazard) | (state_q == S_BUBBLE);
    bubble_load = ~flush_in & ~hold_in & in_bubble;
    stall_out   = ~flush_in & in_bubble;
    op1_sel     = sel_src(fwd_src_in, fwd_sel1_in);
    op2_sel     = sel_src(fwd_src_in, fwd_sel2_in);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    load_d   = load_q;
    rd_d     = rd_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    bubble_d = bubble_q;
    if (flush_in) begin
      state_d  = S_IDLE;
      cnt_d    = 2'd0;
      valid_d  = 1'b0;
      ctrl_d   = '0;
      load_d   = 1'b0;
      rd_d     = 5'd0;
      op1_d    = '0;
      op2_d    = '0;
      bubble_d = 1'b0;
    end else if (hold_in) begin
      state_d = state_q;
    end else if (bubble_load) begin
      valid_d  = 1'b0;
      ctrl_d   = '0;
      load_d   = 1'b0;
      rd_d     = 5'd0;
      op1_d    = '0;
      op2_d    = '0;
      bubble_d = 1'b1;
      if (state_q == S_IDLE) begin
        if (BUBBLE_CYCLES > 1) begin
          state_d = S_BUBBLE;
          cnt_d   = CNT_INIT;
        end
      end else if (cnt_q == 2'd0) begin
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else begin
      valid_d  = id_valid_in;
      ctrl_d   = id_ctrl_in;
      load_d   = id_load_in;
      rd_d     = id_rd_in;
      op1_d    = op1_sel;
      op2_d    = op2_sel;
      bubble_d = 1'b0;
    end
  end

  // ID -> EX register boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      load_q   <= 1'b0;
      rd_q     <= 5'd0;
      op1_q    <= '0;
      op2_q    <= '0;
      bubble_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      load_q   <= load_d;
      rd_q     <= rd_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      bubble_q <= bubble_d;
    end
  end

`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [31:0] bcount_q, bcount_d;

  always_comb begin
    bcount_d = bcount_q;
    if (bubble_load) bcount_d = sat_inc32(bcount_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bcount_q <= 32'd0;
    else       bcount_q <= bcount_d;
  end

  assign bubble_count_out = bcount_q;
`endif

  assign ex_valid_out = valid_q;
  assign ex_ctrl_out  = ctrl_q;
  assign ex_load_out  = load_q;
  assign ex_rd_out    = rd_q;
  assign ex_op1_out   = op1_q;
  assign ex_op2_out   = op2_q;
  assign bubble_out   = bubble_q;

endmodule
